// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: head-of-queue PC/instruction with valid/ready.
// Latency: none, wires only.
// Backpressure: decode holds if_ready low to stall; the producer keeps the head stable meanwhile.
// Signals: if_valid (queue not empty), if_ready (decode accepts), if_pc / if_insn (queue head).
interface instruction_fetch_queue_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_insn;

    // Fetch side drives the head; decode side drives ready.
    modport master (
        output if_valid,
        output if_pc,
        output if_insn,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_pc,
        input  if_insn,
        output if_ready
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Generic flushable FIFO with a combinational head view.
// Latency: push visible at the head the cycle after the write edge.
// Backpressure: push is dropped when full without a pop; the producer must track credits.
// Ports: clk, reset_n, i_flush, i_push_vld/i_push_dat, i_pop_rdy, o_head_dat, o_count.
module ifq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic                   i_push_vld,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop_rdy,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop_rdy & ~w_empty;
    assign w_push  = i_push_vld & (~w_full | w_pop);

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Flush wins over any same-cycle push or pop.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

// Instruction fetch unit: PC sequencer, synchronous instruction RAM and a small fetch queue to decode.
// Latency: issue in cycle t, entry valid to decode in t+2; redirect at t gives first valid at t+3.
// Backpressure: issue only while queue occupancy plus the in-flight read is below FQ_DEPTH.
// Ports: clk, reset_n (async, active low), run, insn_addr/insn_din/insn_we (RAM write),
//        pc_in/pc_in_en (redirect), dec (if_valid/if_ready/if_pc/if_insn), fq_count (occupancy).
module instruction_fetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h8000_0000,
    parameter int          IMEM_AW    = 12,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    input  logic [31:0]                 insn_addr,
    input  logic [31:0]                 insn_din,
    input  logic                        insn_we,
    input  logic [31:0]                 pc_in,
    input  logic                        pc_in_en,
    instruction_fetch_queue_if.master   dec,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fq_entry_t;

    logic [31:0]        r_imem [2**IMEM_AW];
    logic [31:0]        r_pc;
    logic [31:0]        r_rdata;
    logic [31:0]        r_inflight_pc;
    logic               r_inflight;

    logic [CW:0]        w_occ;
    logic               w_issue;
    logic               w_flush;
    logic               w_enq;
    logic [CW-1:0]      w_count;
    fq_entry_t          w_enq_dat;
    fq_entry_t          w_head;
    logic [IMEM_AW-1:0] w_rd_idx;
    logic [IMEM_AW-1:0] w_wr_idx;
    logic               w_unused_bits;

    assign w_rd_idx = r_pc[IMEM_AW+1:2];
    assign w_wr_idx = insn_addr[IMEM_AW+1:2];

    // Address bits outside the word index are intentionally ignored.
    assign w_unused_bits = ^{insn_addr[31:IMEM_AW+2], insn_addr[1:0], pc_in[1:0]};

    // Credit check counts the outstanding read so a full queue can never be overrun;
    // it uses the registered count, so a same-cycle dequeue does not free a slot early.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = run & ~pc_in_en & (w_occ < (CW+1)'(FQ_DEPTH));

    // run low and redirect both discard everything queued or in flight.
    assign w_flush = ~run | pc_in_en;
    assign w_enq   = r_inflight & ~w_flush;

    assign w_enq_dat.pc   = r_inflight_pc;
    assign w_enq_dat.insn = r_rdata;

    // Instruction RAM is never cleared; writes are blocked only while in reset.
    always_ff @(posedge clk) begin
        if (reset_n && insn_we) begin
            r_imem[w_wr_idx] <= insn_din;
        end
    end

    // Read sees the pre-write contents when a write hits the same word this cycle.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rdata <= r_imem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= START_ADDR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (!run) begin
                r_pc <= START_ADDR;
            end else if (pc_in_en) begin
                r_pc <= {pc_in[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    ifq_fifo #(
        .W     ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_flush    (w_flush),
        .i_push_vld (w_enq),
        .i_push_dat (w_enq_dat),
        .i_pop_rdy  (dec.if_ready),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign dec.if_valid = (w_count != '0);
    assign dec.if_pc    = w_head.pc;
    assign dec.if_insn  = w_head.insn;
    assign fq_count     = w_count;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: reset, streaming, backpressure, redirects,
// same-cycle write/read and asynchronous mid-stream reset, all with hand-computed expectations.
module tb_instruction_fetch_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [31:0] insn_addr;
    logic [31:0] insn_din;
    logic        insn_we;
    logic [31:0] pc_in;
    logic        pc_in_en;
    logic [2:0]  fq_count;

    int n_pass  = 0;
    int n_total = 0;

    instruction_fetch_queue_if dec();

    instruction_fetch_queue #(
        .START_ADDR (32'h8000_0000),
        .IMEM_AW    (12),
        .FQ_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .insn_addr (insn_addr),
        .insn_din  (insn_din),
        .insn_we   (insn_we),
        .pc_in     (pc_in),
        .pc_in_en  (pc_in_en),
        .dec       (dec),
        .fq_count  (fq_count)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] insn);
        chk({tag, "_valid"}, 32'(dec.if_valid), 32'd1);
        chk({tag, "_pc"},    dec.if_pc,         pc);
        chk({tag, "_insn"},  dec.if_insn,       insn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        run          = 1'b0;
        insn_we      = 1'b0;
        insn_addr    = '0;
        insn_din     = '0;
        pc_in        = '0;
        pc_in_en     = 1'b0;
        dec.if_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(dec.if_valid), 32'd0);
        chk("rst_count", 32'(fq_count),     32'd0);
        chk("rst_pc",    dec.if_pc,         32'd0);
        chk("rst_insn",  dec.if_insn,       32'd0);

        step();
        reset_n = 1'b1;

        // Preload word[i] = i with run low.
        for (int i = 0; i < 128; i++) begin
            insn_we   = 1'b1;
            insn_addr = 32'h8000_0000 + 32'(i * 4);
            insn_din  = 32'(i);
            step();
        end
        insn_we = 1'b0;
        chk("run0_valid", 32'(dec.if_valid), 32'd0);

        // Streaming: first valid two edges after run rises, then one per cycle.
        run          = 1'b1;
        dec.if_ready = 1'b1;
        step();
        chk("stream_c1_valid", 32'(dec.if_valid), 32'd0);
        step();
        for (int j = 0; j < 6; j++) begin
            chk_head("stream", 32'h8000_0000 + 32'(j * 4), 32'(j));
            chk("stream_count", 32'(fq_count), 32'd1);
            step();
        end

        // Backpressure: fill, hold, then drain without gap or duplicate.
        run          = 1'b0;
        dec.if_ready = 1'b0;
        step();
        chk("stop_valid", 32'(dec.if_valid), 32'd0);
        chk("stop_count", 32'(fq_count),     32'd0);
        run = 1'b1;
        repeat (10) step();
        chk("full_count", 32'(fq_count), 32'd4);
        chk_head("full_head", 32'h8000_0000, 32'd0);
        dec.if_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk_head("drain", 32'h8000_0000 + 32'(j * 4), 32'(j));
            step();
        end

        // Redirect with three entries queued.
        run          = 1'b0;
        dec.if_ready = 1'b0;
        step();
        run = 1'b1;
        repeat (4) step();
        chk("pre_redir_count", 32'(fq_count), 32'd3);
        pc_in    = 32'h8000_0100;
        pc_in_en = 1'b1;
        step();
        pc_in_en = 1'b0;
        chk("redir_t1_valid", 32'(dec.if_valid), 32'd0);
        chk("redir_t1_count", 32'(fq_count),     32'd0);
        step();
        chk("redir_t2_valid", 32'(dec.if_valid), 32'd0);
        step();
        chk_head("redir_t3", 32'h8000_0100, 32'd64);

        // Redirect together with a dequeue: nothing stale may appear.
        dec.if_ready = 1'b1;
        pc_in        = 32'h8000_0042;
        pc_in_en     = 1'b1;
        step();
        pc_in_en = 1'b0;
        chk("rd_deq_valid", 32'(dec.if_valid), 32'd0);
        chk("rd_deq_count", 32'(fq_count),     32'd0);
        step();
        chk("rd_deq_t2_valid", 32'(dec.if_valid), 32'd0);
        step();
        chk_head("rd_deq_h0", 32'h8000_0040, 32'd16);
        step();
        chk_head("rd_deq_h1", 32'h8000_0044, 32'd17);

        // Write to the word being fetched: old data first, new data on refetch.
        run = 1'b0;
        step();
        run       = 1'b1;
        insn_we   = 1'b1;
        insn_addr = 32'h8000_0000;
        insn_din  = 32'hDEAD_BEEF;
        step();
        insn_we = 1'b0;
        step();
        chk_head("wr_old", 32'h8000_0000, 32'd0);
        pc_in    = 32'h8000_0000;
        pc_in_en = 1'b1;
        step();
        pc_in_en = 1'b0;
        step();
        step();
        chk_head("wr_new", 32'h8000_0000, 32'hDEAD_BEEF);
        step();
        chk_head("wr_next", 32'h8000_0004, 32'd1);

        // Asynchronous reset with a full queue, then restart.
        dec.if_ready = 1'b0;
        repeat (8) step();
        chk("pre_arst_count", 32'(fq_count), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dec.if_valid), 32'd0);
        chk("arst_count", 32'(fq_count),     32'd0);
        chk("arst_pc",    dec.if_pc,         32'd0);
        chk("arst_insn",  dec.if_insn,       32'd0);
        step();
        #2;
        reset_n      = 1'b1;
        dec.if_ready = 1'b1;
        step();
        chk("restart_c1_valid", 32'(dec.if_valid), 32'd0);
        step();
        chk_head("restart_h0", 32'h8000_0000, 32'hDEAD_BEEF);
        step();
        chk_head("restart_h1", 32'h8000_0004, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
